// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and round-robin helper for the dual-core AXI arbiter
package axi_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA
    } write_fsm_t;

    localparam int NUM_MASTERS = 2;

    // Grant index for a two-way request; on a tie the master not served last wins
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[0] ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/axi_dual_core_arbiter_rr.sv
// rtl/axi_dual_core_arbiter_rr.sv - two-master round-robin arbiter (rr_arbiter2) with limit masks
module rr_arbiter2
    import axi_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic [1:0] ok_i,
    input  logic       advance_i,
    input  logic       served_i,
    output logic       grant_o,
    output logic       valid_o
);

    // prio_q names the master that wins a tie; 0 after reset
    logic       prio_q;
    logic       prio_d;
    logic [1:0] elig;

    assign elig    = req_i & ok_i;
    assign valid_o = |elig;
    assign grant_o = rr_pick(elig, ~prio_q);

    // After a completed grant, priority moves to the master that was not served
    always_comb begin
        prio_d = advance_i ? ~served_i : prio_q;
    end

    // Priority pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/axi_dual_core_arbiter.sv
// rtl/axi_dual_core_arbiter.sv - shares one AXI slave between two cores; AXI_ARB_PERF_EN adds perf counters
module axi_dual_core_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ID_W                   = 6,
    parameter int ADDR_W                 = 32,
    parameter int DATA_W                 = 32,
    parameter int MAX_OUTSTANDING_READS  = 4,
    parameter int MAX_OUTSTANDING_WRITES = 2,
    parameter int ID_MASTER_BIT          = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
`ifdef AXI_ARB_PERF_EN
    output logic [1:0][31:0]               perf_rd_grants,
    output logic [1:0][31:0]               perf_wr_grants,
    output logic [1:0][31:0]               perf_stall,
`endif
    input  logic [1:0][ID_W-1:0]           m_arid_i,
    input  logic [1:0][ADDR_W-1:0]         m_araddr_i,
    input  logic [1:0][7:0]                m_arlen_i,
    input  logic [1:0]                     m_arvalid_i,
    output logic [1:0]                     m_arready_o,
    output logic [1:0][ID_W-1:0]           m_rid_o,
    output logic [1:0][DATA_W-1:0]         m_rdata_o,
    output logic [1:0][1:0]                m_rresp_o,
    output logic [1:0]                     m_rlast_o,
    output logic [1:0]                     m_rvalid_o,
    input  logic [1:0]                     m_rready_i,
    input  logic [1:0][ID_W-1:0]           m_awid_i,
    input  logic [1:0][ADDR_W-1:0]         m_awaddr_i,
    input  logic [1:0][7:0]                m_awlen_i,
    input  logic [1:0]                     m_awvalid_i,
    output logic [1:0]                     m_awready_o,
    input  logic [1:0][DATA_W-1:0]         m_wdata_i,
    input  logic [1:0][DATA_W/8-1:0]       m_wstrb_i,
    input  logic [1:0]                     m_wlast_i,
    input  logic [1:0]                     m_wvalid_i,
    output logic [1:0]                     m_wready_o,
    output logic [1:0][ID_W-1:0]           m_bid_o,
    output logic [1:0][1:0]                m_bresp_o,
    output logic [1:0]                     m_bvalid_o,
    input  logic [1:0]                     m_bready_i,
    output logic [ID_W-1:0]                s_arid_o,
    output logic [ADDR_W-1:0]              s_araddr_o,
    output logic [7:0]                     s_arlen_o,
    output logic                           s_arvalid_o,
    input  logic                           s_arready_i,
    input  logic [ID_W-1:0]                s_rid_i,
    input  logic [DATA_W-1:0]              s_rdata_i,
    input  logic [1:0]                     s_rresp_i,
    input  logic                           s_rlast_i,
    input  logic                           s_rvalid_i,
    output logic                           s_rready_o,
    output logic [ID_W-1:0]                s_awid_o,
    output logic [ADDR_W-1:0]              s_awaddr_o,
    output logic [7:0]                     s_awlen_o,
    output logic                           s_awvalid_o,
    input  logic                           s_awready_i,
    output logic [DATA_W-1:0]              s_wdata_o,
    output logic [DATA_W/8-1:0]            s_wstrb_o,
    output logic                           s_wlast_o,
    output logic                           s_wvalid_o,
    input  logic                           s_wready_i,
    input  logic [ID_W-1:0]                s_bid_i,
    input  logic [1:0]                     s_bresp_i,
    input  logic                           s_bvalid_i,
    output logic                           s_bready_o
);

    localparam int              WC_W   = $clog2(MAX_OUTSTANDING_WRITES + 1);
    localparam logic [2:0]      RD_MAX = 3'(MAX_OUTSTANDING_READS);
    localparam logic [WC_W-1:0] WR_MAX = WC_W'(MAX_OUTSTANDING_WRITES);

    logic [1:0][2:0]      rd_cnt_q, rd_cnt_d;
    logic [1:0][WC_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]           rd_ok, wr_ok, rd_inc, rd_dec, wr_inc, wr_dec;
    logic                 ar_lock_q, ar_lock_d, ar_lock_own_q, ar_lock_own_d;
    logic                 ar_grant, ar_valid, ar_owner, ar_hs;
    logic                 aw_grant, aw_valid, aw_hs, w_last_hs;
    write_fsm_t           wr_state_q, wr_state_d;
    logic                 wr_own_q, wr_own_d;
    logic                 r_dest, b_dest;

    // A master may only be granted while it has room for another outstanding burst
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            rd_ok[i] = rd_cnt_q[i] < RD_MAX;
            wr_ok[i] = wr_cnt_q[i] < WR_MAX;
        end
    end

    rr_arbiter2 u_ar_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (m_arvalid_i),
        .ok_i      (rd_ok),
        .advance_i (ar_hs),
        .served_i  (ar_owner),
        .grant_o   (ar_grant),
        .valid_o   (ar_valid)
    );

    rr_arbiter2 u_aw_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (m_awvalid_i),
        .ok_i      (wr_ok),
        .advance_i (w_last_hs),
        .served_i  (wr_own_q),
        .grant_o   (aw_grant),
        .valid_o   (aw_valid)
    );

    // A stalled AR keeps its owner so the downstream payload cannot change mid-handshake
    assign ar_owner = ar_lock_q ? ar_lock_own_q : ar_grant;
    assign ar_hs    = s_arvalid_o & s_arready_i;

    // AR mux: owner payload with its index stamped into the ID; outputs forced low in reset
    always_comb begin
        s_arvalid_o                = rst_n & (ar_lock_q ? m_arvalid_i[ar_lock_own_q] : ar_valid);
        s_arid_o                   = m_arid_i[ar_owner];
        s_arid_o[ID_MASTER_BIT]    = ar_owner;
        s_araddr_o                 = m_araddr_i[ar_owner];
        s_arlen_o                  = m_arlen_i[ar_owner];
        m_arready_o                = '0;
        m_arready_o[ar_owner]      = s_arvalid_o & s_arready_i;
        ar_lock_d                  = s_arvalid_o & ~s_arready_i;
        ar_lock_own_d              = ar_owner;
    end

    assign r_dest = s_rid_i[ID_MASTER_BIT];
    assign b_dest = s_bid_i[ID_MASTER_BIT];

    // R and B steering by the master bit of the returned ID; that bit is cleared on the way back
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rid_o[i]                = s_rid_i;
            m_rid_o[i][ID_MASTER_BIT] = 1'b0;
            m_rdata_o[i]              = s_rdata_i;
            m_rresp_o[i]              = s_rresp_i;
            m_rlast_o[i]              = s_rlast_i;
            m_rvalid_o[i]             = rst_n & s_rvalid_i & (r_dest == 1'(i));
            m_bid_o[i]                = s_bid_i;
            m_bid_o[i][ID_MASTER_BIT] = 1'b0;
            m_bresp_o[i]              = s_bresp_i;
            m_bvalid_o[i]             = rst_n & s_bvalid_i & (b_dest == 1'(i));
        end
        s_rready_o = rst_n & m_rready_i[r_dest];
        s_bready_o = rst_n & m_bready_i[b_dest];
    end

    assign aw_hs     = s_awvalid_o & s_awready_i;
    assign w_last_hs = s_wvalid_o & s_wready_i & s_wlast_o;

    // Write FSM next state: pick an owner in idle, hold it through address and the whole burst
    always_comb begin
        wr_state_d = wr_state_q;
        wr_own_d   = wr_own_q;
        case (wr_state_q)
            W_IDLE: if (aw_valid) begin
                wr_own_d   = aw_grant;
                wr_state_d = W_ADDR;
            end
            W_ADDR:  if (aw_hs) wr_state_d = W_DATA;
            W_DATA:  if (w_last_hs) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs: only the owner sees ready, and only in the phase it is in
    always_comb begin
        s_awid_o                = m_awid_i[wr_own_q];
        s_awid_o[ID_MASTER_BIT] = wr_own_q;
        s_awaddr_o              = m_awaddr_i[wr_own_q];
        s_awlen_o               = m_awlen_i[wr_own_q];
        s_wdata_o               = m_wdata_i[wr_own_q];
        s_wstrb_o               = m_wstrb_i[wr_own_q];
        s_wlast_o               = m_wlast_i[wr_own_q];
        s_awvalid_o             = 1'b0;
        s_wvalid_o              = 1'b0;
        m_awready_o             = '0;
        m_wready_o              = '0;
        case (wr_state_q)
            W_ADDR: begin
                s_awvalid_o           = m_awvalid_i[wr_own_q];
                m_awready_o[wr_own_q] = s_awvalid_o & s_awready_i;
            end
            W_DATA: begin
                s_wvalid_o           = m_wvalid_i[wr_own_q];
                m_wready_o[wr_own_q] = s_wvalid_o & s_wready_i;
            end
            default: ;
        endcase
    end

    // Outstanding counts: simultaneous inc/dec cancels, decrement saturates at zero
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            rd_inc[i]   = ar_hs & (ar_owner == 1'(i));
            rd_dec[i]   = s_rvalid_i & s_rready_o & s_rlast_i & (r_dest == 1'(i));
            wr_inc[i]   = w_last_hs & (wr_own_q == 1'(i));
            wr_dec[i]   = s_bvalid_i & s_bready_o & (b_dest == 1'(i));
            rd_cnt_d[i] = rd_cnt_q[i];
            wr_cnt_d[i] = wr_cnt_q[i];
            if (rd_inc[i] && !rd_dec[i]) begin
                rd_cnt_d[i] = rd_cnt_q[i] + 3'd1;
            end else if (rd_dec[i] && !rd_inc[i] && rd_cnt_q[i] != '0) begin
                rd_cnt_d[i] = rd_cnt_q[i] - 3'd1;
            end
            if (wr_inc[i] && !wr_dec[i]) begin
                wr_cnt_d[i] = wr_cnt_q[i] + 1'b1;
            end else if (wr_dec[i] && !wr_inc[i] && wr_cnt_q[i] != '0) begin
                wr_cnt_d[i] = wr_cnt_q[i] - 1'b1;
            end
        end
    end

    // State registers: write FSM, AR lock and outstanding counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q    <= W_IDLE;
            wr_own_q      <= 1'b0;
            ar_lock_q     <= 1'b0;
            ar_lock_own_q <= 1'b0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
        end else begin
            wr_state_q    <= wr_state_d;
            wr_own_q      <= wr_own_d;
            ar_lock_q     <= ar_lock_d;
            ar_lock_own_q <= ar_lock_own_d;
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
        end
    end

    rd_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_dec[0] && rd_cnt_q[0] == '0) && !(rd_dec[1] && rd_cnt_q[1] == '0));
    wr_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_dec[0] && wr_cnt_q[0] == '0) && !(wr_dec[1] && wr_cnt_q[1] == '0));

`ifdef AXI_ARB_PERF_EN
    // Per-master grant and stall counters, free-running with natural 32-bit wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_grants <= '0;
            perf_wr_grants <= '0;
            perf_stall     <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (rd_inc[i]) perf_rd_grants[i] <= perf_rd_grants[i] + 32'd1;
                if (aw_hs && wr_own_q == 1'(i)) perf_wr_grants[i] <= perf_wr_grants[i] + 32'd1;
                if ((m_arvalid_i[i] && !m_arready_o[i]) || (m_awvalid_i[i] && !m_awready_o[i])) begin
                    perf_stall[i] <= perf_stall[i] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_dual_core_arbiter.sv
// tb/tb_axi_dual_core_arbiter.sv - directed self-checking bench for axi_dual_core_arbiter
module tb_axi_dual_core_arbiter;
    import axi_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0][5:0]  m_arid_i, m_rid_o, m_awid_i, m_bid_o;
    logic [1:0][31:0] m_araddr_i, m_rdata_o, m_awaddr_i, m_wdata_i;
    logic [1:0][7:0]  m_arlen_i, m_awlen_i;
    logic [1:0][3:0]  m_wstrb_i;
    logic [1:0][1:0]  m_rresp_o, m_bresp_o;
    logic [1:0] m_arvalid_i, m_arready_o, m_rlast_o, m_rvalid_o, m_rready_i;
    logic [1:0] m_awvalid_i, m_awready_o, m_wlast_i, m_wvalid_i, m_wready_o;
    logic [1:0] m_bvalid_o, m_bready_i;
    logic [5:0]  s_arid_o, s_rid_i, s_awid_o, s_bid_i;
    logic [31:0] s_araddr_o, s_rdata_i, s_awaddr_o, s_wdata_o;
    logic [7:0]  s_arlen_o, s_awlen_o;
    logic [3:0]  s_wstrb_o;
    logic [1:0]  s_rresp_i, s_bresp_i;
    logic s_arvalid_o, s_arready_i, s_rlast_i, s_rvalid_i, s_rready_o;
    logic s_awvalid_o, s_awready_i, s_wlast_o, s_wvalid_o, s_wready_i;
    logic s_bvalid_i, s_bready_o;
`ifdef AXI_ARB_PERF_EN
    logic [1:0][31:0] perf_rd_grants, perf_wr_grants, perf_stall;
`endif

    axi_dual_core_arbiter dut (
        .clk(clk), .rst_n(rst_n),
`ifdef AXI_ARB_PERF_EN
        .perf_rd_grants(perf_rd_grants), .perf_wr_grants(perf_wr_grants), .perf_stall(perf_stall),
`endif
        .m_arid_i(m_arid_i), .m_araddr_i(m_araddr_i), .m_arlen_i(m_arlen_i),
        .m_arvalid_i(m_arvalid_i), .m_arready_o(m_arready_o),
        .m_rid_o(m_rid_o), .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o), .m_rlast_o(m_rlast_o),
        .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i),
        .m_awid_i(m_awid_i), .m_awaddr_i(m_awaddr_i), .m_awlen_i(m_awlen_i),
        .m_awvalid_i(m_awvalid_i), .m_awready_o(m_awready_o),
        .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i), .m_wlast_i(m_wlast_i),
        .m_wvalid_i(m_wvalid_i), .m_wready_o(m_wready_o),
        .m_bid_o(m_bid_o), .m_bresp_o(m_bresp_o), .m_bvalid_o(m_bvalid_o), .m_bready_i(m_bready_i),
        .s_arid_o(s_arid_o), .s_araddr_o(s_araddr_o), .s_arlen_o(s_arlen_o),
        .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i),
        .s_rid_i(s_rid_i), .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rlast_i(s_rlast_i),
        .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o),
        .s_awid_o(s_awid_o), .s_awaddr_o(s_awaddr_o), .s_awlen_o(s_awlen_o),
        .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wlast_o(s_wlast_o),
        .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
        .s_bid_i(s_bid_i), .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] arv;
        logic       sar;
        logic       rbit;
        logic       rv;
        logic [1:0] rr;
        logic       bbit;
        logic       bv;
        logic [1:0] br;
        logic [9:0] exp;   // {s_arvalid, arid bit, m_arready, m_rvalid, s_rready, m_bvalid, s_bready}
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        m_arid_i = '0; m_araddr_i = '0; m_arlen_i = '0; m_arvalid_i = '0; m_rready_i = '0;
        m_awid_i = '0; m_awaddr_i = '0; m_awlen_i = '0; m_awvalid_i = '0;
        m_wdata_i = '0; m_wstrb_i = '0; m_wlast_i = '0; m_wvalid_i = '0; m_bready_i = '0;
        s_arready_i = 0; s_rid_i = '0; s_rdata_i = '0; s_rresp_i = '0; s_rlast_i = 0; s_rvalid_i = 0;
        s_awready_i = 0; s_wready_i = 0; s_bid_i = '0; s_bresp_i = '0; s_bvalid_i = 0;
    endtask

    task automatic drain_r(input logic dest);
        @(negedge clk);
        s_rid_i = {dest, 5'h01}; s_rvalid_i = 1; s_rlast_i = 1; m_rready_i = 2'b11;
        #1 chk("drain_route", m_rvalid_o, dest ? 2'b10 : 2'b01);
        @(posedge clk);
        #1 s_rvalid_i = 0; s_rlast_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 10'b0_0_00_00_0_00_0};
        vecs[1]  = '{2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 10'b1_0_01_00_0_00_0};
        vecs[2]  = '{2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 10'b1_1_10_00_0_00_0};
        vecs[3]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 10'b1_0_01_00_0_00_0};
        vecs[4]  = '{2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 10'b1_0_00_00_0_00_0};
        vecs[5]  = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 10'b0_0_00_10_1_00_0};
        vecs[6]  = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 10'b0_0_00_10_0_00_0};
        vecs[7]  = '{2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 10'b0_0_00_01_1_00_0};
        vecs[8]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 10'b0_0_00_00_1_00_0};
        vecs[9]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 10'b0_0_00_00_0_10_1};
        vecs[10] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 10'b0_0_00_00_0_01_0};
        vecs[11] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 10'b0_0_00_00_0_01_1};

        // Reset: every valid/ready output low even with all inputs asserted
        rst_n = 0;
        clear_inputs();
        m_arvalid_i = 2'b11; s_arready_i = 1; s_rvalid_i = 1; m_rready_i = 2'b11;
        s_bvalid_i = 1; m_bready_i = 2'b11; m_awvalid_i = 2'b11; m_wvalid_i = 2'b11;
        s_awready_i = 1; s_wready_i = 1;
        #1 chk("reset_outputs", {s_arvalid_o, s_rready_o, s_bready_o, s_awvalid_o, s_wvalid_o,
                                  m_arready_o, m_rvalid_o, m_bvalid_o, m_awready_o, m_wready_o}, '0);
        chk("reset_fsm", dut.wr_state_q, W_IDLE);
        repeat (2) @(negedge clk);
        clear_inputs();
        rst_n = 1;

        // Combinational routing table; inputs dropped again before the next rising edge
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            m_arvalid_i = vecs[v].arv; s_arready_i = vecs[v].sar;
            s_rid_i = {vecs[v].rbit, 5'h00}; s_rvalid_i = vecs[v].rv; m_rready_i = vecs[v].rr;
            s_bid_i = {vecs[v].bbit, 5'h00}; s_bvalid_i = vecs[v].bv; m_bready_i = vecs[v].br;
            #1 chk($sformatf("vec%0d", v), {s_arvalid_o, s_arvalid_o & s_arid_o[5], m_arready_o,
                                            m_rvalid_o, s_rready_o, m_bvalid_o, s_bready_o}, vecs[v].exp);
            #1 clear_inputs();
        end

        // Simultaneous AR: core 0 first, then core 1; R routed by rid bit
        @(negedge clk);
        m_araddr_i[0] = 32'h1000; m_araddr_i[1] = 32'h2000; m_arvalid_i = 2'b11; s_arready_i = 1;
        #1 chk("t1_first", {s_arid_o[5], s_araddr_o, m_arready_o}, {1'b0, 32'h1000, 2'b01});
        @(negedge clk);
        m_arvalid_i = 2'b10;
        #1 chk("t1_second", {s_arid_o[5], s_araddr_o, m_arready_o}, {1'b1, 32'h2000, 2'b10});
        @(negedge clk);
        m_arvalid_i = 2'b00; s_arready_i = 0;
        s_rid_i = 6'h03; s_rdata_i = 32'h11111111; s_rvalid_i = 1; s_rlast_i = 1; m_rready_i = 2'b11;
        #1 chk("t1_r0", {m_rvalid_o, m_rdata_o[0], m_rid_o[0]}, {2'b01, 32'h11111111, 6'h03});
        @(negedge clk);
        s_rid_i = 6'h23; s_rdata_i = 32'h22222222;
        #1 chk("t1_r1", {m_rvalid_o, m_rdata_o[1], m_rid_o[1]}, {2'b10, 32'h22222222, 6'h03});
        @(negedge clk);
        clear_inputs();

        // Read limit: four accepted, fifth held until one burst completes
        m_arvalid_i = 2'b01; s_arready_i = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            m_araddr_i[0] = 32'h100 + 32'(k * 4);
            #1 chk($sformatf("t2_accept%0d", k), m_arready_o, 2'b01);
        end
        @(negedge clk);
        m_araddr_i[0] = 32'h110;
        #1 chk("t2_held", {s_arvalid_o, m_arready_o}, 3'b000);
        @(negedge clk);
        m_arvalid_i = 2'b11; m_araddr_i[1] = 32'h2000;
        #1 chk("t2_core1", {s_arid_o[5], m_arready_o}, 3'b110);
        @(negedge clk);
        m_arvalid_i = 2'b01; s_rid_i = 6'h00; s_rvalid_i = 1; s_rlast_i = 1; m_rready_i = 2'b01;
        #1 chk("t2_still_held", m_arready_o, 2'b00);
        @(negedge clk);
        s_rvalid_i = 0; s_rlast_i = 0;
        #1 chk("t2_fifth", {m_arready_o, s_araddr_o}, {2'b01, 32'h110});
        @(negedge clk);
        clear_inputs();
        for (int k = 0; k < 4; k++) drain_r(1'b0);
        drain_r(1'b1);

        // AR lock: stalled core 0 address is held while core 1 also requests
        @(negedge clk);
        clear_inputs();
        m_araddr_i[0] = 32'h5000; m_araddr_i[1] = 32'h6000; m_arvalid_i = 2'b01;
        #1 chk("t4_start", s_araddr_o, 32'h5000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m_arvalid_i = 2'b11;
            #1 chk($sformatf("t4_lock%0d", k), {s_araddr_o, s_arid_o[5], m_arready_o}, {32'h5000, 3'b000});
        end
        @(negedge clk);
        s_arready_i = 1;
        #1 chk("t4_release", {s_araddr_o, m_arready_o}, {32'h5000, 2'b01});
        @(negedge clk);
        m_arvalid_i = 2'b10;
        #1 chk("t4_next", {s_araddr_o, m_arready_o}, {32'h6000, 2'b10});
        @(negedge clk);
        clear_inputs();
        drain_r(1'b0);
        drain_r(1'b1);

        // Atomic write burst: core 1 AW waits until core 0 finishes all 8 beats
        @(negedge clk);
        clear_inputs();
        m_awaddr_i[0] = 32'h3000; m_awlen_i[0] = 8'd7; m_awvalid_i = 2'b01; m_wvalid_i = 2'b01;
        m_wdata_i[0] = 32'hA0; s_awready_i = 1; s_wready_i = 1;
        #1 chk("t3_idle", {s_awvalid_o, m_awready_o, m_wready_o, s_wvalid_o}, 6'b0);
        @(negedge clk);
        #1 chk("t3_addr", {s_awvalid_o, s_awid_o[5], m_awready_o, m_wready_o, s_awaddr_o},
                          {6'b1_0_01_00, 32'h3000});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m_awvalid_i = (i >= 2) ? 2'b10 : 2'b00;
            m_wvalid_i = (i >= 2) ? 2'b11 : 2'b01;
            m_awaddr_i[1] = 32'h4000; m_wdata_i[0] = 32'hA0 + 32'(i); m_wdata_i[1] = 32'hBB;
            m_wlast_i = {1'b1, (i == 7)};
            #1 chk($sformatf("t3_beat%0d", i), {s_wdata_o, s_wvalid_o, m_wready_o, m_awready_o},
                                              {32'hA0 + 32'(i), 5'b1_01_00});
        end
        @(negedge clk);
        m_wvalid_i = 2'b10;
        #1 chk("t3_idle2", {s_awvalid_o, m_awready_o, m_wready_o}, 5'b0);
        @(negedge clk);
        #1 chk("t3_core1_aw", {s_awvalid_o, s_awid_o[5], m_awready_o, m_wready_o, s_awaddr_o},
                              {6'b1_1_10_00, 32'h4000});
        @(negedge clk);
        m_awvalid_i = 2'b00;
        #1 chk("t3_core1_w", {s_wdata_o, s_wlast_o, m_wready_o}, {32'hBB, 3'b1_10});
        @(negedge clk);
        m_wvalid_i = 2'b00; s_bid_i = 6'h00; s_bvalid_i = 1; m_bready_i = 2'b11;
        #1 chk("t3_b0", {m_bvalid_o, s_bready_o}, 3'b01_1);
        @(negedge clk);
        s_bid_i = 6'h27;
        #1 chk("t3_b1", {m_bvalid_o, m_bid_o[1]}, {2'b10, 6'h07});
        @(negedge clk);
        clear_inputs();

        // Reset during W_DATA beat 3, with one read outstanding
        m_arvalid_i = 2'b10; s_arready_i = 1;
        @(negedge clk);
        clear_inputs();
        m_awvalid_i = 2'b01; m_awaddr_i[0] = 32'h7000; m_wvalid_i = 2'b01;
        s_awready_i = 1; s_wready_i = 1;
        @(negedge clk);
        @(negedge clk);
        m_awvalid_i = 2'b00;
        repeat (3) @(negedge clk);
        m_arvalid_i = 2'b11; s_arready_i = 1; s_rvalid_i = 1; m_rready_i = 2'b11;
        s_bvalid_i = 1; m_bready_i = 2'b11;
        #1 chk("t5_beat3", {s_wvalid_o, m_wready_o}, 3'b1_01);
        #1 rst_n = 0;
        #1 chk("t5_outputs", {s_arvalid_o, s_rready_o, s_bready_o, s_awvalid_o, s_wvalid_o,
                              m_arready_o, m_rvalid_o, m_bvalid_o, m_awready_o, m_wready_o}, '0);
        chk("t5_fsm", dut.wr_state_q, W_IDLE);
        chk("t5_counts", {dut.rd_cnt_q, dut.wr_cnt_q}, '0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1;
        @(negedge clk);
        m_awvalid_i = 2'b01; s_awready_i = 1;
        #1 chk("t5_fresh_idle", m_awready_o, 2'b00);
        @(negedge clk);
        #1 chk("t5_fresh_addr", m_awready_o, 2'b01);
        @(negedge clk);
        m_awvalid_i = 2'b00; m_wvalid_i = 2'b01; m_wlast_i = 2'b01; s_wready_i = 1;
        @(negedge clk);
        clear_inputs();
        s_bid_i = 6'h00; s_bvalid_i = 1; m_bready_i = 2'b01;
        @(negedge clk);
        clear_inputs();

`ifdef AXI_ARB_PERF_EN
        // Core 1 blocked for six cycles behind a stalled core 0 read
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            m_arvalid_i = 2'b11; s_arready_i = 0;
        end
        @(negedge clk);
        s_arready_i = 1;
        @(negedge clk);
        m_arvalid_i = 2'b10;
        @(negedge clk);
        clear_inputs();
        #1 chk("t6_stall1", perf_stall[1], 32'd6);
        chk("t6_rd_grants", {perf_rd_grants[0], perf_rd_grants[1]}, {32'd1, 32'd1});
        drain_r(1'b0);
        drain_r(1'b1);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
